// File: rtl/bnn_layer_seq.sv
// Time-multiplexed binary neural network layer: one XNOR-popcount neuron per cycle.
// Optional argmax tracker enabled by defining BNN_ARGMAX_EN.
module bnn_layer_seq #(
  parameter int unsigned NUM_IN      = 8,
  parameter int unsigned NUM_NEURONS = 4,
  localparam int unsigned PW = $clog2(NUM_IN + 1),
  localparam int unsigned AW = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   cfg_is_thr,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [NUM_IN-1:0]      cfg_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_IN-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_NEURONS-1:0] out_bits,
  output logic [AW-1:0]          out_argmax,
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  localparam logic [PW-1:0] ThrRst  = PW'((NUM_IN + 1) / 2);
  localparam logic [AW-1:0] LastIdx = AW'(NUM_NEURONS - 1);

  state_e                 state_q, state_d;
  logic [AW-1:0]          cnt_q;
  logic [NUM_IN-1:0]      x_q;
  logic [NUM_IN-1:0]      weights_q [NUM_NEURONS];
  logic [PW-1:0]          thr_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] res_q;
  logic                   out_valid_q, busy_q;
  logic [NUM_IN-1:0]      match;
  logic [PW-1:0]          pop;
  logic                   cfg_fire, in_fire, cfg_hit, computing;

  assign cfg_ready = (state_q == StIdle);
  // A config write takes priority; the input waits a cycle.
  assign in_ready  = (state_q == StIdle) && !cfg_valid;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;
  assign cfg_hit   = 32'(cfg_addr) < NUM_NEURONS;
  assign computing = (state_q == StCompute);

  assign match = ~(x_q ^ weights_q[cnt_q]);

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      pop = pop + PW'(match[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_fire) state_d = StCompute;
      StCompute: if (cnt_q == LastIdx) state_d = StDone;
      StDone:    if (out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      x_q         <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == StDone);
      busy_q      <= (state_d != StIdle);
      if (in_fire) begin
        x_q   <= in_data;
        res_q <= '0;
        cnt_q <= '0;
      end else if (computing) begin
        res_q[cnt_q] <= (pop >= thr_q[cnt_q]);
        cnt_q        <= (cnt_q == LastIdx) ? '0 : cnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        weights_q[k] <= '0;
        thr_q[k]     <= ThrRst;
      end
    end else if (cfg_fire && cfg_hit) begin
      if (cfg_is_thr) thr_q[cfg_addr] <= cfg_data[PW-1:0];
      else            weights_q[cfg_addr] <= cfg_data;
    end
  end

`ifdef BNN_ARGMAX_EN
  logic [PW-1:0] max_q;
  logic [AW-1:0] arg_q;

  // Strictly-greater update keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      arg_q <= '0;
    end else if (in_fire) begin
      max_q <= '0;
      arg_q <= '0;
    end else if (computing && (pop > max_q)) begin
      max_q <= pop;
      arg_q <= cnt_q;
    end
  end

  assign out_argmax = arg_q;
`else
  assign out_argmax = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_bits  = res_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Self-checking bench for bnn_layer_seq: vector table plus hand-written
// backpressure, config/input conflict and mid-compute reset sequences.
`timescale 1ns/1ps
module tb_bnn_layer_seq;
  localparam int unsigned NI = 8;
  localparam int unsigned NN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0, cfg_ready, cfg_is_thr = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [NI-1:0] cfg_data = '0;
  logic          in_valid = 1'b0, in_ready;
  logic [NI-1:0] in_data = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [NN-1:0] out_bits;
  logic [1:0]    out_argmax;
  logic          busy;

  always #5 clk = ~clk;

  bnn_layer_seq #(.NUM_IN(NI), .NUM_NEURONS(NN)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_is_thr(cfg_is_thr),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_argmax(out_argmax), .busy(busy)
  );

  typedef struct packed {
    logic [3:0] bits;
    logic [1:0] arg;
  } exp_t;

  typedef struct {
    logic        do_cfg;
    logic [31:0] w;     // neuron k weight at [8k+:8]
    logic [15:0] t;     // neuron k threshold at [4k+:4]
    logic [7:0]  x;
    logic [3:0]  bits;
    logic [1:0]  arg;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [3:0] bits, input logic [1:0] arg);
    exp_t e;
    e.bits = bits;
`ifdef BNN_ARGMAX_EN
    e.arg = arg;
`else
    e.arg = 2'd0;
`endif
    return e;
  endfunction

  task automatic cfg_write(input logic thr, input logic [1:0] a, input logic [7:0] d);
    bit done;
    done = 0;
    cfg_valid = 1'b1; cfg_is_thr = thr; cfg_addr = a; cfg_data = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    cfg_valid = 1'b0;
    check("cfg_accept", 32'(done), 32'd1);
  endtask

  task automatic send(input logic [7:0] x, output bit ok);
    ok = 0;
    in_valid = 1'b1; in_data = x;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
      end
    end
    in_valid = 1'b0;
    check("in_accept", 32'(ok), 32'd1);
  endtask

  task automatic collect(input string name, input int hold);
    int lat;
    exp_t e;
    logic [3:0] b0;
    bit stable;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), NN);
    check({name, "_sb"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_bits"}, 32'(out_bits), 32'(e.bits));
      check({name, "_argmax"}, 32'(out_argmax), 32'(e.arg));
    end
    b0 = out_bits;
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_bits !== b0 || out_valid !== 1'b1) stable = 0;
    end
    if (hold > 0) begin
      check({name, "_hold_stable"}, 32'(stable), 32'd1);
      check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({name, "_hold_cfg_ready"}, 32'(cfg_ready), 32'd0);
      check({name, "_hold_busy"}, 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_drop_valid"}, 32'(out_valid), 32'd0);
    check({name, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    check({name, "_keep_bits"}, 32'(out_bits), 32'(b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    vecs[0] = '{1'b0, 32'h0,        16'h4444, 8'h0F, 4'b1111, 2'd0};
    vecs[1] = '{1'b1, 32'hFFAA0FF0, 16'h0866, 8'hF0, 4'b1001, 2'd0};
    vecs[2] = '{1'b1, 32'h00000000, 16'h9888, 8'h00, 4'b0111, 2'd0};
    vecs[3] = '{1'b1, 32'hFF0FFF00, 16'h9481, 8'hFF, 4'b0110, 2'd1};
    vecs[4] = '{1'b1, 32'h33003CC3, 16'h5470, 8'h3C, 4'b0111, 2'd1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bits", 32'(out_bits), 32'd0);
    check("rst_out_argmax", 32'(out_argmax), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].do_cfg) begin
        for (int k = 0; k < NN; k++) begin
          cfg_write(1'b0, 2'(k), vecs[i].w[8*k +: 8]);
          cfg_write(1'b1, 2'(k), {4'h0, vecs[i].t[4*k +: 4]});
        end
      end
      send(vecs[i].x, ok);
      if (ok) sb.push_back(mk_exp(vecs[i].bits, vecs[i].arg));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      collect($sformatf("vec%0d", i), (i == 1) ? 10 : 0);
    end

    // Same-cycle config and input: config (w2 = FF) wins, input follows next cycle.
    cfg_valid = 1'b1; cfg_is_thr = 1'b0; cfg_addr = 2'd2; cfg_data = 8'hFF;
    in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    check("conflict_in_ready", 32'(in_ready), 32'd0);
    check("conflict_cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("conflict_next_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(mk_exp(4'b0101, 2'd2));
    collect("conflict", 0);

    // Reset during the second COMPUTE cycle wipes weights and thresholds.
    send(8'h07, ok);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_bits", 32'(out_bits), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h07, ok);
    if (ok) sb.push_back(mk_exp(4'b1111, 2'd0));
    collect("post_rst", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
